// File: rtl/best_mv_select_if.sv
// rtl/best_mv_select_if.sv - candidate SAD input and best-MV result bundle for best_mv_select
interface best_mv_select_if #(
    parameter int NUM_PART = 8,
    parameter int SAD_W    = 16,
    parameter int CNT_W    = 7,
    parameter int MV_W     = 8
);
    logic                      start;
    logic                      sad_valid;
    logic                      sad_last;
    logic [NUM_PART*SAD_W-1:0] sad_in;
    logic [CNT_W-1:0]          search_column_count;
    logic [CNT_W-1:0]          search_row_count;
    logic                      busy;
    logic                      done;
    logic                      result_valid;
    logic [NUM_PART*SAD_W-1:0] best_sad;
    logic [NUM_PART*MV_W-1:0]  best_mv_x;
    logic [NUM_PART*MV_W-1:0]  best_mv_y;

    modport master (
        output start, sad_valid, sad_last, sad_in, search_column_count, search_row_count,
        input  busy, done, result_valid, best_sad, best_mv_x, best_mv_y
    );

    modport slave (
        input  start, sad_valid, sad_last, sad_in, search_column_count, search_row_count,
        output busy, done, result_valid, best_sad, best_mv_x, best_mv_y
    );
endinterface

// File: rtl/best_mv_select.sv
// rtl/best_mv_select.sv - per-partition minimum SAD / motion vector tracker for one CU search window
module best_mv_select #(
    parameter int NUM_PART     = 8,
    parameter int SAD_W        = 16,
    parameter int CNT_W        = 7,
    parameter int MV_W         = 8,
    parameter int SEARCH_RANGE = 32
) (
    input logic             clk,
    input logic             rst,
    best_mv_select_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_FLUSH, S_DONE} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic                      r_s1_valid;
    logic                      r_first;
    logic                      r_result_valid;
    logic [NUM_PART*SAD_W-1:0] r_s1_sad;
    logic [CNT_W-1:0]          r_s1_col;
    logic [CNT_W-1:0]          r_s1_row;
    logic [SAD_W-1:0]          r_best_sad  [NUM_PART];
    logic [MV_W-1:0]           r_best_mv_x [NUM_PART];
    logic [MV_W-1:0]           r_best_mv_y [NUM_PART];
    logic [MV_W-1:0]           w_mv_x;
    logic [MV_W-1:0]           w_mv_y;
    logic                      w_accept;

    // start wins over a candidate presented in the same cycle
    assign w_accept = (r_state == S_SEARCH) && bus.sad_valid && !bus.start;
    assign w_mv_x   = MV_W'((MV_W+1)'(r_s1_col) - (MV_W+1)'(SEARCH_RANGE));
    assign w_mv_y   = MV_W'((MV_W+1)'(r_s1_row) - (MV_W+1)'(SEARCH_RANGE));

    always_comb begin
        w_next = r_state;
        if (bus.start) begin
            w_next = S_SEARCH;
        end else begin
            case (r_state)
                S_IDLE:   w_next = S_IDLE;
                S_SEARCH: if (bus.sad_valid && bus.sad_last) w_next = S_FLUSH;
                S_FLUSH:  w_next = S_DONE;
                S_DONE:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_s1_valid     <= 1'b0;
            r_s1_sad       <= '0;
            r_s1_col       <= '0;
            r_s1_row       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sad <= bus.sad_in;
                r_s1_col <= bus.search_column_count;
                r_s1_row <= bus.search_row_count;
            end
            if (bus.start)
                r_result_valid <= 1'b0;
            else if (r_state == S_FLUSH)
                r_result_valid <= 1'b1;
        end
    end

    // Strict less-than keeps the raster-first candidate on ties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first <= 1'b0;
            for (int p = 0; p < NUM_PART; p++) begin
                r_best_sad[p]  <= '1;
                r_best_mv_x[p] <= '0;
                r_best_mv_y[p] <= '0;
            end
        end else if (bus.start) begin
            r_first <= 1'b1;
            for (int p = 0; p < NUM_PART; p++) begin
                r_best_sad[p]  <= '1;
                r_best_mv_x[p] <= '0;
                r_best_mv_y[p] <= '0;
            end
        end else if (r_s1_valid) begin
            r_first <= 1'b0;
            for (int p = 0; p < NUM_PART; p++) begin
                if (r_first || (r_s1_sad[p*SAD_W +: SAD_W] < r_best_sad[p])) begin
                    r_best_sad[p]  <= r_s1_sad[p*SAD_W +: SAD_W];
                    r_best_mv_x[p] <= w_mv_x;
                    r_best_mv_y[p] <= w_mv_y;
                end
            end
        end
    end

    assign bus.busy         = (r_state == S_SEARCH) || (r_state == S_FLUSH);
    assign bus.done         = (r_state == S_DONE);
    assign bus.result_valid = r_result_valid;

    for (genvar g = 0; g < NUM_PART; g++) begin : g_lane
        assign bus.best_sad[g*SAD_W +: SAD_W] = r_best_sad[g];
        assign bus.best_mv_x[g*MV_W +: MV_W]  = r_best_mv_x[g];
        assign bus.best_mv_y[g*MV_W +: MV_W]  = r_best_mv_y[g];
    end
endmodule

// File: tb/tb_best_mv_select.sv
// tb/tb_best_mv_select.sv - directed testbench for best_mv_select
module tb_best_mv_select;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    best_mv_select_if #(.NUM_PART(8), .SAD_W(16), .CNT_W(7), .MV_W(8)) bus ();

    best_mv_select #(
        .NUM_PART(8), .SAD_W(16), .CNT_W(7), .MV_W(8), .SEARCH_RANGE(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cand(input logic [127:0] sads, input logic [6:0] col, input logic [6:0] row,
                            input logic last, input logic valid);
        bus.sad_in              = sads;
        bus.search_column_count = col;
        bus.search_row_count    = row;
        bus.sad_last            = last;
        bus.sad_valid           = valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        set_cand('0, 7'd0, 7'd0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        if (bus.busy !== 1'b0) begin $display("FAIL reset_busy got %b exp 0", bus.busy); n_fail++; end
        n_tests++;
        if (bus.done !== 1'b0) begin $display("FAIL reset_done got %b exp 0", bus.done); n_fail++; end
        n_tests++;
        if (bus.result_valid !== 1'b0) begin $display("FAIL reset_rv got %b exp 0", bus.result_valid); n_fail++; end
        n_tests++;
        if (bus.best_sad !== {8{16'hFFFF}}) begin $display("FAIL reset_sad got %h exp all ones", bus.best_sad); n_fail++; end
        n_tests++;
        if (bus.best_mv_x !== 64'h0 || bus.best_mv_y !== 64'h0) begin
            $display("FAIL reset_mv got %h/%h exp 0/0", bus.best_mv_x, bus.best_mv_y); n_fail++;
        end
        n_tests++;
        for (int i = 0; i < 3; i++) begin
            set_cand('0, 7'd5, 7'd5, 1'b1, 1'b1);
            step();
        end
        set_cand('0, 7'd0, 7'd0, 1'b0, 1'b0);
        step();
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result_valid !== 1'b0) begin
            $display("FAIL idle_ignore_ctrl got busy=%b done=%b rv=%b exp 0 0 0", bus.busy, bus.done, bus.result_valid);
            n_fail++;
        end
        n_tests++;
        if (bus.best_sad !== {8{16'hFFFF}} || bus.best_mv_x !== 64'h0) begin
            $display("FAIL idle_ignore_best got %h/%h exp ones/0", bus.best_sad, bus.best_mv_x); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_basic();
        logic [127:0] s;
        s = {8{16'h0001}};
        bus.start = 1'b1;
        set_cand(s, 7'd0, 7'd0, 1'b1, 1'b1);
        step();
        bus.start = 1'b0;
        if (bus.busy !== 1'b1) begin $display("FAIL basic_busy got %b exp 1", bus.busy); n_fail++; end
        n_tests++;
        s = {8{16'h1000}}; s[15:0] = 16'd500;
        set_cand(s, 7'd30, 7'd32, 1'b0, 1'b1);
        step();
        s[15:0] = 16'd200;
        set_cand(s, 7'd34, 7'd31, 1'b0, 1'b1);
        step();
        s[15:0] = 16'd300;
        set_cand(s, 7'd40, 7'd40, 1'b1, 1'b1);
        step();
        set_cand('0, 7'd0, 7'd0, 1'b0, 1'b0);
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            $display("FAIL basic_flush got done=%b busy=%b exp 0 1", bus.done, bus.busy); n_fail++;
        end
        n_tests++;
        if (bus.best_sad[15:0] !== 16'd200) begin $display("FAIL basic_lat got %0d exp 200", bus.best_sad[15:0]); n_fail++; end
        n_tests++;
        step();
        if (bus.done !== 1'b1 || bus.result_valid !== 1'b1 || bus.busy !== 1'b0) begin
            $display("FAIL basic_done got done=%b rv=%b busy=%b exp 1 1 0", bus.done, bus.result_valid, bus.busy);
            n_fail++;
        end
        n_tests++;
        if (bus.best_sad[15:0] !== 16'd200 || bus.best_mv_x[7:0] !== 8'h02 || bus.best_mv_y[7:0] !== 8'hFF) begin
            $display("FAIL basic_lane0 got %0d %h %h exp 200 02 ff",
                     bus.best_sad[15:0], bus.best_mv_x[7:0], bus.best_mv_y[7:0]);
            n_fail++;
        end
        n_tests++;
        if (bus.best_sad[31:16] !== 16'h1000 || bus.best_mv_x[15:8] !== 8'hFE || bus.best_mv_y[15:8] !== 8'h00) begin
            $display("FAIL basic_lane1 got %h %h %h exp 1000 fe 00",
                     bus.best_sad[31:16], bus.best_mv_x[15:8], bus.best_mv_y[15:8]);
            n_fail++;
        end
        n_tests++;
        step();
        if (bus.done !== 1'b0 || bus.result_valid !== 1'b1) begin
            $display("FAIL basic_after got done=%b rv=%b exp 0 1", bus.done, bus.result_valid); n_fail++;
        end
        n_tests++;
        step();
        if (bus.result_valid !== 1'b1 || bus.best_sad[15:0] !== 16'd200) begin
            $display("FAIL basic_hold got rv=%b sad=%0d exp 1 200", bus.result_valid, bus.best_sad[15:0]); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_tie();
        logic [127:0] s;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        s = {8{16'hFFFF}}; s[31:16] = 16'd100; s[15:0] = 16'd50;
        set_cand(s, 7'd0, 7'd0, 1'b0, 1'b1);
        step();
        s[15:0] = 16'd40;
        set_cand(s, 7'd63, 7'd63, 1'b1, 1'b1);
        step();
        set_cand('0, 7'd0, 7'd0, 1'b0, 1'b0);
        step();
        if (bus.done !== 1'b1) begin $display("FAIL tie_done got %b exp 1", bus.done); n_fail++; end
        n_tests++;
        if (bus.best_sad[31:16] !== 16'd100 || bus.best_mv_x[15:8] !== 8'hE0 || bus.best_mv_y[15:8] !== 8'hE0) begin
            $display("FAIL tie_lane1 got %0d %h %h exp 100 e0 e0",
                     bus.best_sad[31:16], bus.best_mv_x[15:8], bus.best_mv_y[15:8]);
            n_fail++;
        end
        n_tests++;
        if (bus.best_sad[47:32] !== 16'hFFFF || bus.best_mv_x[23:16] !== 8'hE0 || bus.best_mv_y[23:16] !== 8'hE0) begin
            $display("FAIL tie_allones got %h %h %h exp ffff e0 e0",
                     bus.best_sad[47:32], bus.best_mv_x[23:16], bus.best_mv_y[23:16]);
            n_fail++;
        end
        n_tests++;
        if (bus.best_sad[15:0] !== 16'd40 || bus.best_mv_x[7:0] !== 8'h1F || bus.best_mv_y[7:0] !== 8'h1F) begin
            $display("FAIL tie_lane0 got %0d %h %h exp 40 1f 1f",
                     bus.best_sad[15:0], bus.best_mv_x[7:0], bus.best_mv_y[7:0]);
            n_fail++;
        end
        n_tests++;
        step();
    endtask

    task automatic test_lanes();
        logic [127:0] s;
        logic [6:0]   cols [4];
        logic [6:0]   rows [4];
        logic [7:0]   ex   [4];
        logic [7:0]   ey   [4];
        cols = '{7'd32, 7'd40, 7'd20, 7'd63};
        rows = '{7'd32, 7'd0,  7'd50, 7'd45};
        ex   = '{8'h00, 8'h08, 8'hF4, 8'h1F};
        ey   = '{8'h00, 8'hE0, 8'h12, 8'h0D};
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 8; p++)
                s[p*16 +: 16] = ((p % 4) == k) ? 16'(10 + p) : 16'(1000 + k);
            set_cand(s, cols[k], rows[k], (k == 3), 1'b1);
            step();
        end
        set_cand('0, 7'd0, 7'd0, 1'b0, 1'b0);
        step();
        for (int p = 0; p < 8; p++) begin
            if (bus.best_sad[p*16 +: 16] !== 16'(10 + p) || bus.best_mv_x[p*8 +: 8] !== ex[p % 4] ||
                bus.best_mv_y[p*8 +: 8] !== ey[p % 4]) begin
                $display("FAIL lanes_%0d got %0d %h %h exp %0d %h %h", p, bus.best_sad[p*16 +: 16],
                         bus.best_mv_x[p*8 +: 8], bus.best_mv_y[p*8 +: 8], 10 + p, ex[p % 4], ey[p % 4]);
                n_fail++;
            end
            n_tests++;
        end
        step();
    endtask

    task automatic test_restart();
        logic [127:0] s;
        s = {8{16'h2000}};
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        if (bus.result_valid !== 1'b0) begin $display("FAIL rst_rv_clear got %b exp 0", bus.result_valid); n_fail++; end
        n_tests++;
        s[15:0] = 16'd5;
        set_cand(s, 7'd0, 7'd0, 1'b0, 1'b1);
        step();
        s[15:0] = 16'd6;
        set_cand(s, 7'd1, 7'd1, 1'b0, 1'b1);
        step();
        s[15:0] = 16'd1;
        bus.start = 1'b1;
        set_cand(s, 7'd2, 7'd2, 1'b1, 1'b1);
        step();
        bus.start = 1'b0;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.best_sad[15:0] !== 16'hFFFF) begin
            $display("FAIL restart_search got busy=%b done=%b sad=%h exp 1 0 ffff",
                     bus.busy, bus.done, bus.best_sad[15:0]);
            n_fail++;
        end
        n_tests++;
        s[15:0] = 16'd700;
        set_cand(s, 7'd33, 7'd33, 1'b1, 1'b1);
        step();
        set_cand('0, 7'd0, 7'd0, 1'b0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.result_valid !== 1'b0 || bus.best_sad[15:0] !== 16'hFFFF) begin
            $display("FAIL restart_flush got busy=%b done=%b rv=%b sad=%h exp 1 0 0 ffff",
                     bus.busy, bus.done, bus.result_valid, bus.best_sad[15:0]);
            n_fail++;
        end
        n_tests++;
        s[15:0] = 16'd800;
        set_cand(s, 7'd35, 7'd30, 1'b1, 1'b1);
        step();
        set_cand('0, 7'd0, 7'd0, 1'b0, 1'b0);
        step();
        if (bus.done !== 1'b1 || bus.best_sad[15:0] !== 16'd800 || bus.best_mv_x[7:0] !== 8'h03 ||
            bus.best_mv_y[7:0] !== 8'hFE) begin
            $display("FAIL restart_result got done=%b %0d %h %h exp 1 800 03 fe",
                     bus.done, bus.best_sad[15:0], bus.best_mv_x[7:0], bus.best_mv_y[7:0]);
            n_fail++;
        end
        n_tests++;
        step();
    endtask

    task automatic test_reset_flush();
        logic [127:0] s;
        s = {8{16'h3000}};
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        s[15:0] = 16'd9;
        set_cand(s, 7'd40, 7'd40, 1'b1, 1'b1);
        step();
        set_cand('0, 7'd0, 7'd0, 1'b0, 1'b0);
        if (bus.busy !== 1'b1) begin $display("FAIL rflush_busy got %b exp 1", bus.busy); n_fail++; end
        n_tests++;
        #2 rst = 1'b1;
        #1;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result_valid !== 1'b0 ||
            bus.best_sad !== {8{16'hFFFF}} || bus.best_mv_x !== 64'h0 || bus.best_mv_y !== 64'h0) begin
            $display("FAIL rflush_async got busy=%b done=%b rv=%b sad=%h exp 0 0 0 ones",
                     bus.busy, bus.done, bus.result_valid, bus.best_sad);
            n_fail++;
        end
        n_tests++;
        step();
        rst = 1'b0;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        s[15:0] = 16'd77;
        set_cand(s, 7'd32, 7'd36, 1'b1, 1'b1);
        step();
        set_cand('0, 7'd0, 7'd0, 1'b0, 1'b0);
        step();
        if (bus.done !== 1'b1 || bus.result_valid !== 1'b1 || bus.best_sad[15:0] !== 16'd77 ||
            bus.best_mv_x[7:0] !== 8'h00 || bus.best_mv_y[7:0] !== 8'h04) begin
            $display("FAIL rflush_rerun got done=%b rv=%b %0d %h %h exp 1 1 77 00 04", bus.done,
                     bus.result_valid, bus.best_sad[15:0], bus.best_mv_x[7:0], bus.best_mv_y[7:0]);
            n_fail++;
        end
        n_tests++;
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_tie();
        test_lanes();
        test_restart();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
